// File: rtl/sdram_frame_sched_if.sv
// ---------------------------------------------------------------------------
// sdram_frame_sched_if
// Purpose : bundles the FIFO fill levels, vsync, the write/read burst
//           handshakes toward sdram_top and the scheduler status flags.
// Modports:
//   master - the frame scheduler (drives requests, addresses, status)
//   slave  - the environment (FIFOs, display timing, sdram_top)
// Signals :
//   wr_fifo_used_i [FIFO_W] capture FIFO fill level
//   rd_fifo_used_i [FIFO_W] display FIFO fill level
//   vsync_i                 synchronised display vsync (low = blanking)
//   wr_req_o / wr_ack_i     write burst request / completion
//   wr_addr_o [24]          {bank[1:0], row[12:0], col[8:0]=0}
//   rd_req_o / rd_ack_i     read burst request / completion
//   rd_addr_o [24]          same format as wr_addr_o
//   frame_ready_o           sticky, first full frame written
//   wr_stall_o              writer blocked by bank conflict
//   err_o                   sticky, ack timeout seen
// ---------------------------------------------------------------------------
interface sdram_frame_sched_if #(
  parameter int FIFO_W = 11
);
  logic [FIFO_W-1:0] wr_fifo_used_i;
  logic [FIFO_W-1:0] rd_fifo_used_i;
  logic              vsync_i;
  logic              wr_req_o;
  logic              wr_ack_i;
  logic [23:0]       wr_addr_o;
  logic              rd_req_o;
  logic              rd_ack_i;
  logic [23:0]       rd_addr_o;
  logic              frame_ready_o;
  logic              wr_stall_o;
  logic              err_o;

  modport master (
    input  wr_fifo_used_i, rd_fifo_used_i, vsync_i, wr_ack_i, rd_ack_i,
    output wr_req_o, wr_addr_o, rd_req_o, rd_addr_o,
           frame_ready_o, wr_stall_o, err_o
  );

  modport slave (
    output wr_fifo_used_i, rd_fifo_used_i, vsync_i, wr_ack_i, rd_ack_i,
    input  wr_req_o, wr_addr_o, rd_req_o, rd_addr_o,
           frame_ready_o, wr_stall_o, err_o
  );
endinterface

// File: rtl/sdram_frame_sched.sv
// ---------------------------------------------------------------------------
// sdram_frame_sched
// Purpose : schedules row-burst writes (capture FIFO -> SDRAM) and reads
//           (SDRAM -> display FIFO) with one outstanding transaction,
//           round-robin arbitration on ties, an ack timeout with a sticky
//           error flag and optional ping-pong banking.
// Ports   :
//   clk_i  - scheduler clock (133 MHz SDRAM clock)
//   rst_i  - asynchronous active-high reset
//   bus    - sdram_frame_sched_if.master (FIFO levels, vsync, burst
//            handshakes, addresses, status flags)
// Build option:
//   SDRAM_PINGPONG_EN - when defined, frames alternate between banks 0 and
//   1 and the writer stalls if it would overwrite the bank being displayed.
//   When undefined, capture is one-shot into bank 0 and reads replay it.
// ---------------------------------------------------------------------------
module sdram_frame_sched #(
  parameter int FIFO_W      = 11,
  parameter int FRAME_ROWS  = 128,
  parameter int WR_THRESH   = 512,
  parameter int RD_THRESH   = 512,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sdram_frame_sched_if.master bus
);

  localparam int                TW       = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]     TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [12:0]       LAST_ROW = 13'(FRAME_ROWS - 1);
  localparam logic [FIFO_W-1:0] WR_TH    = FIFO_W'(WR_THRESH);
  localparam logic [FIFO_W-1:0] RD_TH    = FIFO_W'(RD_THRESH);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last_wr;      // 1 when the last completed grant was a write
  logic [TW-1:0] r_tmo_cnt;
  logic [12:0]   r_wr_row;
  logic [12:0]   r_rd_row;
  logic [1:0]    r_wr_bank;
  logic [1:0]    r_rd_bank;
  logic [1:0]    r_done_bank;    // bank holding the most recent complete frame
  logic          r_wr_done;      // one-shot writer has finished its frame
  logic          r_rd_done;      // reader has delivered the whole frame
  logic          r_frame_ready;
  logic          r_err;
  logic          r_wr_req;
  logic          r_rd_req;
  logic [23:0]   r_wr_addr;
  logic [23:0]   r_rd_addr;

  logic w_we;
  logic w_re;
  logic w_tmo;
  logic w_wr_ack;
  logic w_rd_ack;
  logic w_wr_stall;

`ifdef SDRAM_PINGPONG_EN
  // The write bank has already toggled to the next frame's bank, so a match
  // with the displayed bank means the writer would overwrite it.
  assign w_wr_stall = r_frame_ready && (r_wr_bank == r_rd_bank);
`else
  assign w_wr_stall = 1'b0;
`endif

  assign w_we     = (bus.wr_fifo_used_i >= WR_TH) && !r_wr_done && !w_wr_stall;
  assign w_re     = bus.vsync_i && r_frame_ready && !r_rd_done &&
                    (bus.rd_fifo_used_i <= RD_TH);
  assign w_tmo    = (r_tmo_cnt == TMO_LAST);
  assign w_wr_ack = (r_state == WR_REQ) && bus.wr_ack_i;
  assign w_rd_ack = (r_state == RD_REQ) && bus.rd_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_we && w_re)  w_state_next = r_last_wr ? RD_REQ : WR_REQ;
        else if (w_we)     w_state_next = WR_REQ;
        else if (w_re)     w_state_next = RD_REQ;
      end
      WR_REQ:  if (bus.wr_ack_i || w_tmo) w_state_next = IDLE;
      RD_REQ:  if (bus.rd_ack_i || w_tmo) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_wr     <= 1'b0;
      r_tmo_cnt     <= '0;
      r_wr_row      <= '0;
      r_rd_row      <= '0;
      r_wr_bank     <= '0;
      r_rd_bank     <= '0;
      r_done_bank   <= '0;
      r_wr_done     <= 1'b0;
      r_rd_done     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_err         <= 1'b0;
      r_wr_req      <= 1'b0;
      r_rd_req      <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
    end else begin
      r_wr_req <= (w_state_next == WR_REQ);
      r_rd_req <= (w_state_next == RD_REQ);

      // Counter restarts whenever a request state is entered or left.
      if (r_state == IDLE || w_state_next != r_state) r_tmo_cnt <= '0;
      else                                             r_tmo_cnt <= r_tmo_cnt + 1'b1;

      // An ack in the timeout cycle still counts as a completion.
      if (r_state != IDLE && w_tmo && !w_wr_ack && !w_rd_ack) r_err <= 1'b1;

      if (w_wr_ack) begin
        r_last_wr <= 1'b1;
        if (r_wr_row == LAST_ROW) begin
          r_wr_row      <= '0;
          r_frame_ready <= 1'b1;
          r_done_bank   <= r_wr_bank;
`ifdef SDRAM_PINGPONG_EN
          r_wr_bank     <= {1'b0, ~r_wr_bank[0]};
`else
          r_wr_done     <= 1'b1;
`endif
        end else begin
          r_wr_row <= r_wr_row + 13'd1;
        end
      end

      if (w_rd_ack) begin
        r_last_wr <= 1'b0;
        if (!bus.vsync_i) begin
          // Frame restarted while this burst was in flight: discard its row.
          r_rd_row  <= '0;
          r_rd_done <= 1'b0;
        end else if (r_rd_row == LAST_ROW) begin
          r_rd_row  <= '0;
          r_rd_done <= 1'b1;
        end else begin
          r_rd_row <= r_rd_row + 13'd1;
        end
      end

      if (!bus.vsync_i && r_state != RD_REQ) begin
        r_rd_row  <= '0;
        r_rd_bank <= r_done_bank;
        r_rd_done <= 1'b0;
      end

      // Addresses track the row/bank outside their own request so they are
      // settled before the next grant, and stay frozen during the burst.
      if (r_state != WR_REQ) r_wr_addr <= {r_wr_bank, r_wr_row, 9'd0};
      if (r_state != RD_REQ) r_rd_addr <= {r_rd_bank, r_rd_row, 9'd0};
    end
  end

  assign bus.wr_req_o      = r_wr_req;
  assign bus.rd_req_o      = r_rd_req;
  assign bus.wr_addr_o     = r_wr_addr;
  assign bus.rd_addr_o     = r_rd_addr;
  assign bus.frame_ready_o = r_frame_ready;
  assign bus.wr_stall_o    = w_wr_stall;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_sdram_frame_sched
// Purpose : directed self-checking bench for sdram_frame_sched with
//           FRAME_ROWS=4, ACK_TIMEOUT=8, thresholds 512. The ping-pong
//           flow runs when SDRAM_PINGPONG_EN is defined, the one-shot flow
//           (plus timeout and vsync checks) otherwise.
// ---------------------------------------------------------------------------
module tb_sdram_frame_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  sdram_frame_sched_if #(.FIFO_W(11)) bus ();

  sdram_frame_sched #(
    .FIFO_W(11), .FRAME_ROWS(4), .WR_THRESH(512),
    .RD_THRESH(512), .ACK_TIMEOUT(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(bus.wr_req_o || bus.rd_req_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(bus.wr_req_o | bus.rd_req_o), 32'd1);
  endtask

  // Wait for a request, check kind and address, ack after ack_dly more cycles.
  task automatic do_xact(input string tag, input logic is_wr,
                         input logic [31:0] addr, input int ack_dly);
    wait_req(tag);
    check({tag, "_wr"}, 32'(bus.wr_req_o), 32'(is_wr));
    check({tag, "_rd"}, 32'(bus.rd_req_o), 32'(!is_wr));
    check({tag, "_addr"}, is_wr ? 32'(bus.wr_addr_o) : 32'(bus.rd_addr_o), addr);
    $display("xact %s %s addr=0x%06h", tag, is_wr ? "WR" : "RD",
             is_wr ? bus.wr_addr_o : bus.rd_addr_o);
    repeat (ack_dly) @(negedge clk);
    if (is_wr) bus.wr_ack_i = 1'b1;
    else       bus.rd_ack_i = 1'b1;
    @(negedge clk);
    bus.wr_ack_i = 1'b0;
    bus.rd_ack_i = 1'b0;
    check({tag, "_drop"}, 32'(bus.wr_req_o | bus.rd_req_o), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.wr_req_o || bus.rd_req_o) hits++;
    end
    check(tag, 32'(hits), 32'd0);
    $display("quiet %s cycles=%0d", tag, n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_req"}, 32'(bus.wr_req_o), 32'd0);
    check({tag, "_rd_req"}, 32'(bus.rd_req_o), 32'd0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr_o), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr_o), 32'd0);
    check({tag, "_ready"}, 32'(bus.frame_ready_o), 32'd0);
    check({tag, "_stall"}, 32'(bus.wr_stall_o), 32'd0);
    check({tag, "_err"}, 32'(bus.err_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.wr_fifo_used_i = 11'd0;
    bus.rd_fifo_used_i = 11'd1000;
    bus.vsync_i        = 1'b1;
    bus.wr_ack_i       = 1'b0;
    bus.rd_ack_i       = 1'b0;

    // Reset state, then reset asserted in the middle of a write request.
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;
    bus.wr_fifo_used_i = 11'd600;
    #1 check("rel_no_req", 32'(bus.wr_req_o), 32'd0);
    @(negedge clk);
    check("first_req", 32'(bus.wr_req_o), 32'd1);
    check("first_addr", 32'(bus.wr_addr_o), 32'd0);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    $display("reset released with wr_fifo_used=600");

    // Frame fill with a write-threshold boundary probe between rows 0 and 1.
    do_xact("w0", 1'b1, 32'd0, 2);
    bus.wr_fifo_used_i = 11'd511;
    expect_quiet("wr_thresh_511", 4);
    bus.wr_fifo_used_i = 11'd512;
    do_xact("w1", 1'b1, 32'h200, 2);
    do_xact("w2", 1'b1, 32'h400, 2);
    check("ready_before_end", 32'(bus.frame_ready_o), 32'd0);
    do_xact("w3", 1'b1, 32'h600, 2);
    check("ready_at_end", 32'(bus.frame_ready_o), 32'd1);

`ifdef SDRAM_PINGPONG_EN
    check("pp_stall_f1", 32'(bus.wr_stall_o), 32'd0);
    // Both eligible: last grant was a write, so reads lead and grants alternate.
    bus.rd_fifo_used_i = 11'd100;
    for (int r = 0; r < 4; r++) begin
      do_xact($sformatf("pp_r%0d", r), 1'b0, 32'(r) << 9, 2);
      do_xact($sformatf("pp_w%0d", r), 1'b1, 32'h400000 | (32'(r) << 9), 2);
    end
    // Next frame would land in bank 0, which is still on display.
    check("pp_stall_on", 32'(bus.wr_stall_o), 32'd1);
    expect_quiet("pp_stalled", 10);
    check("pp_stall_held", 32'(bus.wr_stall_o), 32'd1);
    bus.wr_fifo_used_i = 11'd0;
    bus.vsync_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pp_stall_off", 32'(bus.wr_stall_o), 32'd0);
    check("pp_rd_bank1", 32'(bus.rd_addr_o), 32'h400000);
    bus.vsync_i = 1'b1;
    bus.wr_fifo_used_i = 11'd600;
    do_xact("pp3_r0", 1'b0, 32'h400000, 2);
    do_xact("pp3_w0", 1'b1, 32'h000000, 2);
    do_xact("pp3_r1", 1'b0, 32'h400200, 2);
    do_xact("pp3_w1", 1'b1, 32'h000200, 2);
    check("pp_err", 32'(bus.err_o), 32'd0);
`else
    // One-shot capture: the writer never asks again.
    expect_quiet("no_5th_wr", 20);
    bus.rd_fifo_used_i = 11'd513;
    expect_quiet("rd_thresh_513", 5);
    bus.rd_fifo_used_i = 11'd512;
    for (int r = 0; r < 4; r++)
      do_xact($sformatf("r%0d", r), 1'b0, 32'(r) << 9, 2);
    expect_quiet("rd_frame_end", 10);
    bus.vsync_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.vsync_i = 1'b1;

    // Ack in the last allowed cycle counts; no error.
    do_xact("rv0_ack8", 1'b0, 32'd0, 7);
    check("err_after_ack8", 32'(bus.err_o), 32'd0);

    // No ack: request held exactly 8 cycles, error set, same row retried.
    wait_req("tmo");
    check("tmo_rd", 32'(bus.rd_req_o), 32'd1);
    check("tmo_addr", 32'(bus.rd_addr_o), 32'h200);
    n = 0;
    while (bus.rd_req_o && n < 30) begin
      n++;
      @(negedge clk);
    end
    check("tmo_len", 32'(n), 32'd8);
    check("tmo_err", 32'(bus.err_o), 32'd1);
    $display("timeout rd_req high for %0d cycles", n);
    do_xact("rt1", 1'b0, 32'h200, 2);

    // Vsync falls while row 2 is in flight; the burst completes but the
    // row is discarded and the frame restarts at row 0.
    wait_req("vm");
    check("vm_rd", 32'(bus.rd_req_o), 32'd1);
    check("vm_addr", 32'(bus.rd_addr_o), 32'h400);
    bus.vsync_i = 1'b0;
    @(negedge clk);
    check("vm_req_held", 32'(bus.rd_req_o), 32'd1);
    @(negedge clk);
    bus.rd_ack_i = 1'b1;
    @(negedge clk);
    bus.rd_ack_i = 1'b0;
    check("vm_drop", 32'(bus.rd_req_o), 32'd0);
    repeat (2) @(negedge clk);
    check("vm_row0", 32'(bus.rd_addr_o), 32'd0);
    expect_quiet("vm_vsync_low", 5);
    bus.vsync_i = 1'b1;
    do_xact("vm_r0", 1'b0, 32'd0, 2);
    check("err_sticky", 32'(bus.err_o), 32'd1);
    check("stall_tied", 32'(bus.wr_stall_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_frame_sched.md
# sdram_frame_sched

Single-clock SDRAM frame scheduler for the 133 MHz domain. It generates row-burst write and read requests toward `sdram_top`: capture FIFO to SDRAM, and SDRAM to display FIFO. This is the parametrised successor to the ad-hoc write/read request machines at top level, and adds the following:

- one outstanding transaction with round-robin arbitration;
- parametrised frame height and FIFO thresholds;
- an ack timeout with an error flag;
- optional ping-pong double buffering across SDRAM banks.

## Interface
Parameters:
- `FIFO_W`, 11, width of the FIFO fill-level inputs.
- `FRAME_ROWS`, 128, SDRAM rows per frame (1..8192); one row is one 512-word burst.
- `WR_THRESH`, 512, write is eligible when `wr_fifo_used_i >= WR_THRESH`.
- `RD_THRESH`, 512, read is eligible when `rd_fifo_used_i <= RD_THRESH`.
- `ACK_TIMEOUT`, 4096, number of request cycles without ack before the request is abandoned (≥2).

Ports:
- `clk_i` in 1: scheduler clock (133 MHz SDRAM clock).
- `rst_i` in 1: asynchronous, active-high reset.
- `wr_fifo_used_i` in FIFO_W: capture FIFO fill level.
- `rd_fifo_used_i` in FIFO_W: display FIFO fill level.
- `vsync_i` in 1: display vsync, already synchronised; low means blanking or frame restart.
- `wr_req_o` out 1: write burst request to `sdram_top`.
- `wr_ack_i` in 1: write burst complete.
- `wr_addr_o` out 24: `{bank[1:0], row[12:0], col[8:0]=0}`.
- `rd_req_o` out 1: read burst request.
- `rd_ack_i` in 1: read burst complete.
- `rd_addr_o` out 24: same format as `wr_addr_o`.
- `frame_ready_o` out 1: sticky; set when the first full frame has been written.
- `wr_stall_o` out 1: writer blocked by a bank conflict (ping-pong only).
- `err_o` out 1: sticky; set on ack timeout.

## Operation
States: `IDLE`, `WR_REQ`, `RD_REQ`.

- **Write eligible (`we`):** `wr_fifo_used_i >= WR_THRESH` and writer not finished and not stalled.
- **Read eligible (`re`):** `vsync_i==1` and `frame_ready_o` and `rd_row < FRAME_ROWS` and `rd_fifo_used_i <= RD_THRESH`.
- **IDLE:**
  - only `we` → `WR_REQ`;
  - only `re` → `RD_REQ`;
  - both → grant the opposite of the last grant (`last_grant` resets to read, so the first tie goes to write).
- **WR_REQ / RD_REQ:**
  - The request stays high until ack.
  - On ack: request drops, row increments, state → `IDLE`, `last_grant` is updated.
- **Timeout:** the timeout counter clears on state entry. At count `ACK_TIMEOUT-1` with no ack:
  - request drops, state → `IDLE`;
  - row is not advanced;
  - `err_o` is set.
  - If ack arrives in the same cycle as the timeout, ack wins.
- **Write end of frame:** on the ack with `wr_row == FRAME_ROWS-1`:
  - `wr_row` → 0;
  - `frame_ready_o` is set;
  - `done_bank` ← current write bank.
- **Vsync low:**
  - While `vsync_i==0` in `IDLE` or `WR_REQ`: `rd_row` is held at 0 and `rd_bank` ← `done_bank`.
  - A read in flight when vsync falls completes normally. Its ack does not advance `rd_row`, which then clears.
- Row arithmetic is 13-bit. Rows never exceed `FRAME_ROWS-1`, so there is no wrap beyond the frame.
- Address outputs are registered. `rd_addr_o` is frozen while `rd_req_o` is high.

## Timing
- **Reset:** all outputs 0; rows 0; banks 0; state `IDLE`.
- **Request latency:** the request goes high on the edge after the cycle in which eligibility is true in `IDLE`.
- **Ack:** sampled on the edge.
  - The request is low on the following edge.
  - At least one `IDLE` cycle separates consecutive requests, so the request is never held through a new ack.
- A new grant is evaluated in the `IDLE` cycle after the request drops.
- **Reset mid-request:** the request drops asynchronously. No completion is recorded.

## Configuration
- `SDRAM_PINGPONG_EN` defined:
  - Write bank starts at 0 and toggles at each frame end, so capture runs continuously.
  - If the next write bank equals `rd_bank` while `frame_ready_o` is set, the writer stalls (`wr_stall_o`=1, no `we`) until vsync low re-latches `rd_bank`.
- `SDRAM_PINGPONG_EN` undefined:
  - Single bank 0; `wr_stall_o` is tied to 0.
  - The writer stops permanently after `FRAME_ROWS` rows (one-shot capture).
  - Reads replay bank 0 every frame.

## Test plan
- **Reset:** assert `rst_i` mid-`WR_REQ` → `wr_req_o`=0 immediately, all outputs 0; after release with `wr_fifo_used_i`=600, `wr_req_o`=1 two edges later with `wr_addr_o`=0.
- **Frame fill:** `FRAME_ROWS`=4, acks after 3 cycles → `wr_addr_o` rows 0,1,2,3; `frame_ready_o` rises on the 4th ack; undefined macro → no 5th request.
- **Arbitration:** `we` and `re` held true → grants alternate W,R,W,R; `rd_row` 0..3 while `vsync_i`=1; `vsync_i`=0 → next read at row 0.
- **Timeout:** `ACK_TIMEOUT`=8, no ack → `rd_req_o` high exactly 8 cycles, `err_o`=1, same row re-requested; ack on cycle 8 → counted, `err_o` stays 0.
- **Ping-pong:** macro defined → second frame written to bank 1 (`wr_addr_o[23:22]`=1); vsync low → `rd_addr_o[23:22]`=1; third frame into bank 0 while reader is on bank 0 → `wr_stall_o`=1 until vsync low.
- **Vsync mid-read:** vsync falls during `RD_REQ`, ack 2 cycles later → `rd_row` = 0, no advance.
